// File: rtl/dram_addr_decoder_pkg.sv
// Shared DRAM request types and default address-map geometry.
// Field widths/offsets replace the old fixed address masks.
package dram_addr_decoder_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int BG_BITS_DEF     = 2;
  localparam int BG_OFFSET_DEF   = 6;
  localparam int BANK_BITS_DEF   = 2;
  localparam int BANK_OFFSET_DEF = 8;
  localparam int COL_BITS_DEF    = 8;
  localparam int COL_OFFSET_DEF  = 10;
  localparam int ROW_BITS_DEF    = 14;
  localparam int ROW_OFFSET_DEF  = 18;
  localparam int CNT_W_DEF       = 32;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } parsed_op_t;

  typedef struct packed {
    parsed_op_t              opcode;
    logic [ADDR_W_DEF-1:0]   address;
  } parser_out_struct;

  typedef enum logic [1:0] {
    ROW_HIT   = 2'd0,
    ROW_MISS  = 2'd1,
    ROW_EMPTY = 2'd2
  } row_class_t;

  typedef struct packed {
    logic [BG_BITS_DEF-1:0]   bg;
    logic [BANK_BITS_DEF-1:0] bank;
    logic [COL_BITS_DEF-1:0]  col;
    logic [ROW_BITS_DEF-1:0]  row;
  } dram_fields_t;

  function automatic row_class_t classify(
    input logic is_open,
    input logic tag_eq
  );
    if (!is_open) return ROW_EMPTY;
    if (tag_eq)   return ROW_HIT;
    return ROW_MISS;
  endfunction

endpackage

// File: rtl/dram_addr_decoder_open_row_table.sv
// Per-bank open-row table: open bit plus row tag per bank.
// Lookup sees this cycle's closes; a same-cycle write reopens.
module dram_addr_decoder_open_row_table #(
  parameter int NUM_BANKS = 16,
  parameter int ID_W      = 4,
  parameter int ROW_W     = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ID_W-1:0]  lk_id,
  output logic             lk_open,
  output logic [ROW_W-1:0] lk_row,
  input  logic             close_valid,
  input  logic [ID_W-1:0]  close_id,
  input  logic             close_all,
  input  logic             wr_en,
  input  logic [ID_W-1:0]  wr_id,
  input  logic [ROW_W-1:0] wr_row
);

  logic [NUM_BANKS-1:0] r_open;
  logic [ROW_W-1:0]     r_row [NUM_BANKS];
  logic                 w_lk_closing;

  // Lookup with the current cycle's closes already applied
  always_comb begin
    w_lk_closing = close_all ||
                   (close_valid && (close_id == lk_id));
    lk_open = r_open[lk_id] && !w_lk_closing;
    lk_row  = r_row[lk_id];
  end

  // Closes first, then the access open overrides them
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_open <= '0;
      for (int i = 0; i < NUM_BANKS; i++)
        r_row[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (close_all ||
            (close_valid && (close_id == ID_W'(i))))
          r_open[i] <= 1'b0;
        if (wr_en && (wr_id == ID_W'(i))) begin
          r_open[i] <= 1'b1;
          r_row[i]  <= wr_row;
        end
      end
    end
  end

endmodule

// File: rtl/dram_addr_decoder.sv
// Splits request addresses into DRAM fields and classifies
// each against the open-row table; one output register stage.
module dram_addr_decoder
  import dram_addr_decoder_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDR_W_DEF,
  parameter int BG_BITS       = BG_BITS_DEF,
  parameter int BG_OFFSET     = BG_OFFSET_DEF,
  parameter int BANK_BITS     = BANK_BITS_DEF,
  parameter int BANK_OFFSET   = BANK_OFFSET_DEF,
  parameter int COL_BITS      = COL_BITS_DEF,
  parameter int COL_OFFSET    = COL_OFFSET_DEF,
  parameter int ROW_BITS      = ROW_BITS_DEF,
  parameter int ROW_OFFSET    = ROW_OFFSET_DEF,
  parameter int CNT_WIDTH     = CNT_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  parser_out_struct         in_req,
  output logic                     in_ready,
  input  logic                     close_valid,
  input  logic [BG_BITS+BANK_BITS-1:0] close_id,
  input  logic                     close_all,
  output logic                     out_valid,
  input  logic                     out_ready,
  output parsed_op_t               out_opcode,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic [BG_BITS-1:0]       out_bg,
  output logic [BANK_BITS-1:0]     out_bank,
  output logic [COL_BITS-1:0]      out_col,
  output logic [ROW_BITS-1:0]      out_row,
  output row_class_t               out_class,
  output logic [CNT_WIDTH-1:0]     hit_count,
  output logic [CNT_WIDTH-1:0]     miss_count,
  output logic [CNT_WIDTH-1:0]     empty_count
);

  localparam int ID_W      = BG_BITS + BANK_BITS;
  localparam int NUM_BANKS = 1 << ID_W;

  logic [ADDRESS_WIDTH-1:0] w_addr;
  logic [BG_BITS-1:0]       w_bg;
  logic [BANK_BITS-1:0]     w_bank;
  logic [COL_BITS-1:0]      w_col;
  logic [ROW_BITS-1:0]      w_row;
  logic [ID_W-1:0]          w_id;
  logic                     w_load;
  logic                     w_open;
  logic [ROW_BITS-1:0]      w_tag;
  row_class_t               w_class;

  logic                     r_valid;
  parsed_op_t               r_opcode;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [BG_BITS-1:0]       r_bg;
  logic [BANK_BITS-1:0]     r_bank;
  logic [COL_BITS-1:0]      r_col;
  logic [ROW_BITS-1:0]      r_row;
  row_class_t               r_class;
  logic [CNT_WIDTH-1:0]     r_hit;
  logic [CNT_WIDTH-1:0]     r_miss;
  logic [CNT_WIDTH-1:0]     r_empty;

  // Field split, handshake and classification
  always_comb begin
    w_addr   = in_req.address[ADDRESS_WIDTH-1:0];
    w_bg     = w_addr[BG_OFFSET +: BG_BITS];
    w_bank   = w_addr[BANK_OFFSET +: BANK_BITS];
    w_col    = w_addr[COL_OFFSET +: COL_BITS];
    w_row    = w_addr[ROW_OFFSET +: ROW_BITS];
    w_id     = {w_bg, w_bank};
    in_ready = !r_valid || out_ready;
    w_load   = in_valid && in_ready &&
               (in_req.opcode != OP_NOP);
    w_class  = classify(w_open, w_tag == w_row);
  end

  dram_addr_decoder_open_row_table #(
    .NUM_BANKS (NUM_BANKS),
    .ID_W      (ID_W),
    .ROW_W     (ROW_BITS)
  ) u_table (
    .clock       (clock),
    .reset       (reset),
    .lk_id       (w_id),
    .lk_open     (w_open),
    .lk_row      (w_tag),
    .close_valid (close_valid),
    .close_id    (close_id),
    .close_all   (close_all),
    .wr_en       (w_load),
    .wr_id       (w_id),
    .wr_row      (w_row)
  );

  // Output register and saturating statistics
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_opcode <= OP_NOP;
      r_addr   <= '0;
      r_bg     <= '0;
      r_bank   <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_class  <= ROW_EMPTY;
      r_hit    <= '0;
      r_miss   <= '0;
      r_empty  <= '0;
    end else if (w_load) begin
      r_valid  <= 1'b1;
      r_opcode <= in_req.opcode;
      r_addr   <= w_addr;
      r_bg     <= w_bg;
      r_bank   <= w_bank;
      r_col    <= w_col;
      r_row    <= w_row;
      r_class  <= w_class;
      unique case (w_class)
        ROW_HIT:
          if (r_hit != '1) r_hit <= r_hit + 1'b1;
        ROW_MISS:
          if (r_miss != '1) r_miss <= r_miss + 1'b1;
        default:
          if (r_empty != '1) r_empty <= r_empty + 1'b1;
      endcase
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_opcode  = r_opcode;
  assign out_address = r_addr;
  assign out_bg      = r_bg;
  assign out_bank    = r_bank;
  assign out_col     = r_col;
  assign out_row     = r_row;
  assign out_class   = r_class;
  assign hit_count   = r_hit;
  assign miss_count  = r_miss;
  assign empty_count = r_empty;

endmodule

// File: tb/tb_dram_addr_decoder.sv
// Scoreboard bench for dram_addr_decoder against an
// arithmetic reference model of the address map and row table.
module tb_dram_addr_decoder;
  import dram_addr_decoder_pkg::*;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  parser_out_struct in_req;
  logic             in_ready;
  logic             close_valid;
  logic [3:0]       close_id;
  logic             close_all;
  logic             out_valid;
  logic             out_ready;
  parsed_op_t       out_opcode;
  logic [31:0]      out_address;
  logic [1:0]       out_bg;
  logic [1:0]       out_bank;
  logic [7:0]       out_col;
  logic [13:0]      out_row;
  row_class_t       out_class;
  logic [CW-1:0]    hit_count;
  logic [CW-1:0]    miss_count;
  logic [CW-1:0]    empty_count;

  always #5 clock = ~clock;

  dram_addr_decoder #(.CNT_WIDTH(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_req      (in_req),
    .in_ready    (in_ready),
    .close_valid (close_valid),
    .close_id    (close_id),
    .close_all   (close_all),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_address (out_address),
    .out_bg      (out_bg),
    .out_bank    (out_bank),
    .out_col     (out_col),
    .out_row     (out_row),
    .out_class   (out_class),
    .hit_count   (hit_count),
    .miss_count  (miss_count),
    .empty_count (empty_count)
  );

  typedef struct {
    int unsigned op;
    int unsigned addr;
    int unsigned bg, bank, col, row, cls;
    int unsigned hit, miss, empty;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          m_open[16];
  int unsigned m_row[16];
  bit          m_ov;
  int unsigned m_hit, m_miss, m_empty;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_open[i] = 0;
      m_row[i]  = 0;
    end
    m_ov = 0;
    m_hit = 0; m_miss = 0; m_empty = 0;
    q.delete();
  endfunction

  // Reference behaviour of one clock edge
  function automatic void model_edge();
    bit          rdy, acc;
    int unsigned a, id;
    exp_t        e;
    rdy = !m_ov || out_ready;
    acc = in_valid && rdy;
    if (close_all)
      for (int i = 0; i < 16; i++) m_open[i] = 0;
    else if (close_valid)
      m_open[close_id] = 0;
    if (acc && in_req.opcode != OP_NOP) begin
      a      = in_req.address;
      e.op   = in_req.opcode;
      e.addr = a;
      e.bg   = (a >> 6) & 3;
      e.bank = (a >> 8) & 3;
      e.col  = (a >> 10) & 255;
      e.row  = (a >> 18) & 16383;
      id     = e.bg * 4 + e.bank;
      if (!m_open[id]) begin
        e.cls = ROW_EMPTY;
        if (m_empty < CMAX) m_empty++;
      end else if (m_row[id] == e.row) begin
        e.cls = ROW_HIT;
        if (m_hit < CMAX) m_hit++;
      end else begin
        e.cls = ROW_MISS;
        if (m_miss < CMAX) m_miss++;
      end
      m_open[id] = 1;
      m_row[id]  = e.row;
      e.hit = m_hit; e.miss = m_miss; e.empty = m_empty;
      q.push_back(e);
      m_ov = 1;
    end else if (out_ready) begin
      m_ov = 0;
    end
  endfunction

  // Monitor: compare the presented output with the queue head
  always @(negedge clock) begin
    if (!reset) begin
      chk("in_ready", in_ready, !m_ov || out_ready);
      chk("out_valid", out_valid, m_ov);
      if (m_ov) begin
        if (q.size() == 0) begin
          chk("queue_empty", 1, 0);
        end else begin
          chk("opcode", out_opcode, q[0].op);
          chk("address", out_address, q[0].addr);
          chk("bg", out_bg, q[0].bg);
          chk("bank", out_bank, q[0].bank);
          chk("col", out_col, q[0].col);
          chk("row", out_row, q[0].row);
          chk("class", out_class, q[0].cls);
          chk("hit_count", hit_count, q[0].hit);
          chk("miss_count", miss_count, q[0].miss);
          chk("empty_count", empty_count, q[0].empty);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic step(int unsigned op, int unsigned addr,
                      bit iv, bit ordy, bit cv = 0,
                      int unsigned cid = 0, bit ca = 0);
    in_valid       = iv;
    in_req.opcode  = parsed_op_t'(op[1:0]);
    in_req.address = addr;
    out_ready      = ordy;
    close_valid    = cv;
    close_id       = cid[3:0];
    close_all      = ca;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  function automatic int unsigned rnd_addr();
    int unsigned r;
    r = $urandom_range(1, 3);
    return (r << 18) | ($urandom_range(0, 255) << 10) |
           ($urandom_range(0, 15) << 6) |
           $urandom_range(0, 63);
  endfunction

  task automatic check_reset_vals();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_opcode", out_opcode, OP_NOP);
    chk("rst_address", out_address, 0);
    chk("rst_fields", {out_bg, out_bank, out_col, out_row}, 0);
    chk("rst_class", out_class, ROW_EMPTY);
    chk("rst_counts", {hit_count, miss_count, empty_count}, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    int unsigned op;
    reset = 1;
    in_valid = 0; in_req = '0; out_ready = 1;
    close_valid = 0; close_id = 0; close_all = 0;
    model_reset();
    #12;
    check_reset_vals();
    @(posedge clock); #1;
    reset = 0;

    // Directed address-map and classification cases
    step(OP_READ, 32'h0004_0000, 1, 1);
    step(OP_READ, 32'h0004_0000, 1, 1);
    step(OP_READ, 32'h0008_0000, 1, 1);
    step(OP_WRITE, 32'h0004_0140, 1, 1);
    step(OP_READ, 32'h0004_0140, 1, 1);
    step(OP_READ, 32'h0008_0000, 1, 1, 1, 0);
    step(OP_READ, 32'h0008_0000, 1, 1);
    step(OP_READ, 32'h0004_0140, 1, 1, 0, 0, 1);

    // Stall for three cycles, then drain at full rate
    for (int i = 0; i < 3; i++)
      step(OP_READ, 32'h000C_0000, 1, 0);
    step(OP_READ, 32'h000C_0000, 1, 1);
    step(OP_WRITE, 32'h000C_0400, 1, 1);
    step(OP_READ, 32'h0010_0000, 1, 1);

    // NOPs are swallowed without output
    step(OP_NOP, 32'h0004_0000, 1, 1);
    step(OP_NOP, 32'h0008_0000, 1, 1);
    step(OP_READ, 32'h0, 0, 1);

    // Push the miss counter into saturation
    for (int i = 0; i < 20; i++)
      step(OP_READ, ((i % 2 + 1) << 18) | 32'h300, 1, 1);

    // Randomised traffic with closes and back-pressure
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 5);
      step(op == 0 ? OP_NOP : (op < 4 ? OP_READ : OP_WRITE),
           rnd_addr(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 15),
           $urandom_range(0, 30) == 0);
    end

    // Asynchronous reset in the middle of a transfer
    step(OP_READ, 32'h0004_0000, 1, 0);
    #2;
    reset = 1;
    #1;
    check_reset_vals();
    in_valid = 0;
    model_reset();
    @(posedge clock); #1;
    reset = 0;
    step(OP_READ, 32'h0004_0000, 1, 1);
    step(OP_READ, 32'h0004_0000, 1, 1);
    for (int i = 0; i < 40; i++)
      step(OP_READ, rnd_addr(), $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0);

    // Bounded drain of outstanding results
    for (int i = 0; i < 20 && q.size() != 0; i++)
      step(OP_NOP, 0, 0, 1);
    chk("drain", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
